// File: rtl/rtc_regfile_prot_if.sv
// rtl/rtc_regfile_prot_if.sv - register bus between a host and the protected RTC register file
interface rtc_regfile_prot_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              write_en;
    logic              read_en;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              wr_err;
    logic              rd_err;
    logic              locked;

    modport master (
        output addr, data_in, write_en, read_en,
        input  data_out, rd_valid, wr_err, rd_err, locked
    );

    modport slave (
        input  addr, data_in, write_en, read_en,
        output data_out, rd_valid, wr_err, rd_err, locked
    );
endinterface

// File: rtl/rtc_regfile_prot.sv
// rtl/rtc_regfile_prot.sv - RTC register file with key-sequence unlock gate on the upper range
module rtc_regfile_prot #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int PROT_BASE  = 8,
    parameter int KEY_ADDR   = 15,
    parameter int UNLOCK_TMO = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    rtc_regfile_prot_if.slave   bus
);
    localparam int CNT_W = $clog2(UNLOCK_TMO + 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   PROT_X  = (ADDR_W+1)'(PROT_BASE);
    localparam logic [ADDR_W-1:0] KEY_A   = ADDR_W'(KEY_ADDR);

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_KEY1_OK  = 2'd1,
        S_UNLOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;
    logic              wr_err_q;
    logic              rd_err_q;
    logic              locked_q;

    logic              in_range;
    logic              is_key;
    logic              is_prot;
    logic              key_wr;
    logic              prot_wr;
    logic              store_en;
    logic              wr_reject;
    logic [7:0]        key_byte;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        in_range  = {1'b0, bus.addr} < DEPTH_X;
        is_key    = in_range && (bus.addr == KEY_A);
        is_prot   = in_range && !is_key && ({1'b0, bus.addr} >= PROT_X);
        key_wr    = bus.write_en && is_key;
        prot_wr   = bus.write_en && is_prot && (state == S_UNLOCKED);
        store_en  = bus.write_en && in_range && !is_key && (!is_prot || state == S_UNLOCKED);
        wr_reject = bus.write_en && (!in_range || (is_prot && state != S_UNLOCKED));
        key_byte  = bus.data_in[7:0];
    end

    // Pre-write contents: the store lands on the same edge that registers this value.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.addr == ADDR_W'(i)) rd_data = mem[i];
        end
        if (is_key)        rd_data = {{(DATA_W-2){1'b0}}, state};
        else if (!in_range) rd_data = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (store_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.addr == ADDR_W'(i)) mem[i] <= bus.data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.read_en;
            rd_err_q   <= bus.read_en && !in_range;
            wr_err_q   <= wr_reject;
            if (bus.read_en) data_out_q <= rd_data;
        end
    end

    // Key FSM; a key write takes priority over timeout expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_LOCKED;
            locked_q <= 1'b1;
            cnt      <= '0;
        end else begin
            case (state)
                S_LOCKED: begin
                    if (key_wr && key_byte == 8'h55) state <= S_KEY1_OK;
                end
                S_KEY1_OK: begin
                    if (bus.write_en) begin
                        if (key_wr && key_byte == 8'hAA) begin
                            state    <= S_UNLOCKED;
                            locked_q <= 1'b0;
                            cnt      <= CNT_W'(UNLOCK_TMO);
                        end else begin
                            state <= S_LOCKED;
                        end
                    end
                end
                S_UNLOCKED: begin
                    cnt <= cnt - CNT_W'(1);
                    if (key_wr) begin
                        state    <= (key_byte == 8'h55) ? S_KEY1_OK : S_LOCKED;
                        locked_q <= 1'b1;
                        cnt      <= '0;
                    end else if (prot_wr || cnt == CNT_W'(1)) begin
                        state    <= S_LOCKED;
                        locked_q <= 1'b1;
                        cnt      <= '0;
                    end
                end
                default: begin
                    state    <= S_LOCKED;
                    locked_q <= 1'b1;
                    cnt      <= '0;
                end
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_err   = wr_err_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.locked   = locked_q;
endmodule

// File: tb/tb_rtc_regfile_prot.sv
// tb/tb_rtc_regfile_prot.sv - directed and randomized bench for rtc_regfile_prot
module tb_rtc_regfile_prot;
    localparam int DEPTH = 16;
    localparam int PROT  = 8;
    localparam int KEY   = 15;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtc_regfile_prot_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    rtc_regfile_prot #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(DEPTH), .PROT_BASE(PROT),
        .KEY_ADDR(KEY), .UNLOCK_TMO(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: entries, key state (0 locked, 1 first key seen, 2 unlocked), cycles left open.
    logic [7:0] m_mem [DEPTH];
    int         m_st;
    int         m_left;
    logic [7:0] e_dout;
    logic       e_rv, e_re, e_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("data_out", 32'(bus.data_out), 32'(e_dout));
        chk("rd_valid", 32'(bus.rd_valid), 32'(e_rv));
        chk("rd_err",   32'(bus.rd_err),   32'(e_re));
        chk("wr_err",   32'(bus.wr_err),   32'(e_we));
        chk("locked",   32'(bus.locked),   32'(m_st != 2));
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_st = 0; m_left = 0;
        e_dout = 8'h00; e_rv = 1'b0; e_re = 1'b0; e_we = 1'b0;
    endtask

    task automatic model_edge(input bit we, input bit re, input int a, input logic [7:0] d);
        int  nst;
        bit  prot;
        prot = (a < DEPTH) && (a != KEY) && (a >= PROT);
        e_rv = re;
        e_re = re && (a >= DEPTH);
        if (re) begin
            if (a >= DEPTH)     e_dout = 8'h00;
            else if (a == KEY)  e_dout = 8'(m_st);
            else                e_dout = m_mem[a];
        end
        e_we = 1'b0;
        if (we) begin
            if (a >= DEPTH)            e_we = 1'b1;
            else if (prot) begin
                if (m_st == 2) m_mem[a] = d;
                else           e_we = 1'b1;
            end else if (a != KEY)     m_mem[a] = d;
        end
        nst = m_st;
        if (m_st == 0) begin
            if (we && a == KEY && d == 8'h55) nst = 1;
        end else if (m_st == 1) begin
            if (we) begin
                if (a == KEY && d == 8'hAA) begin
                    nst = 2; m_left = TMO;
                end else nst = 0;
            end
        end else begin
            m_left--;
            if (m_left == 0) nst = 0;
            if (we && a == KEY)  nst = (d == 8'h55) ? 1 : 0;
            else if (we && prot) nst = 0;
        end
        m_st = nst;
    endtask

    task automatic step(input bit we, input bit re, input int a, input logic [7:0] d);
        @(negedge clk);
        bus.write_en = we;
        bus.read_en  = re;
        bus.addr     = 4'(a);
        bus.data_in  = d;
        @(posedge clk);
        model_edge(we, re, a, d);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.write_en = 1'b1; bus.read_en = 1'b1;
        bus.addr = 4'd1; bus.data_in = 8'hEE;
        @(posedge clk);
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        bus.write_en = 1'b0; bus.read_en = 1'b0;
    endtask

    task automatic unlock();
        step(1, 0, KEY, 8'h55);
        step(1, 0, KEY, 8'hAA);
    endtask

    initial begin
        int a;
        logic [7:0] d;
        bit we, re;
        bus.write_en = 1'b0; bus.read_en = 1'b0; bus.addr = '0; bus.data_in = '0;
        model_reset();
        do_reset();

        for (int i = 0; i < 5; i++) step(1, 0, i, 8'(10 + 5 * i));
        for (int i = 0; i < 5; i++) step(0, 1, i, 8'h00);
        step(0, 0, 0, 8'h00);

        step(1, 0, 9, 8'h3C);
        step(0, 1, 9, 8'h00);

        unlock();
        step(1, 0, 9, 8'h3C);
        step(0, 1, 9, 8'h00);
        step(1, 0, 9, 8'h11);
        step(0, 1, 9, 8'h00);

        unlock();
        for (int i = 0; i < TMO; i++) step(0, 0, 0, 8'h00);
        step(1, 0, 10, 8'h5A);
        step(0, 1, KEY, 8'h00);
        unlock();
        for (int i = 0; i < TMO - 1; i++) step(0, 0, 0, 8'h00);
        step(1, 0, 10, 8'h6B);
        step(0, 1, 10, 8'h00);

        step(1, 0, KEY, 8'h55);
        step(1, 0, 2, 8'h07);
        step(1, 0, KEY, 8'hAA);
        step(0, 1, 2, 8'h00);
        step(0, 1, KEY, 8'h00);

        step(1, 1, 3, 8'h40);
        step(0, 1, 3, 8'h00);

        for (int n = 0; n < 600; n++) begin
            we = ($urandom_range(0, 99) < 55);
            re = ($urandom_range(0, 99) < 50);
            case ($urandom_range(0, 3))
                0:       a = KEY;
                1:       a = $urandom_range(PROT, DEPTH - 1);
                default: a = $urandom_range(0, DEPTH - 1);
            endcase
            d = 8'($urandom);
            if (a == KEY) begin
                case ($urandom_range(0, 4))
                    0, 1: d = 8'h55;
                    2, 3: d = 8'hAA;
                    default: d = 8'($urandom);
                endcase
            end
            step(we, re, a, d);
        end

        unlock();
        step(0, 0, 0, 8'h00);
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 1, i, 8'h00);
        step(0, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rtc_regfile_prot.md
# rtc_regfile_prot

Parametrised, write-protected register file for the RTC datapath: the next generation of the RTC register file, with configurable width and depth, registered reads with a valid strobe, error reporting and a key-sequence unlock gate on the upper register range. It holds the RTC time, alarm and configuration registers. Protected entries, from PROT_BASE upward, accept a write only after a two-byte key sequence, so stray bus writes cannot corrupt calibration or time-set registers.

## Interface
- DATA_W, 8: data width; must be ≥ 8; key compare uses data_in[7:0]
- ADDR_W, 4: address width
- DEPTH, 16: number of addressable entries; DEPTH ≤ 2^ADDR_W
- PROT_BASE, 8: first protected address; entries PROT_BASE..DEPTH-1 excluding KEY_ADDR are protected
- KEY_ADDR, 15: key/status address; not a storage entry; must satisfy KEY_ADDR < DEPTH
- UNLOCK_TMO, 16: cycles the unlock window stays open; ≥ 1
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- addr  in  ADDR_W  shared read/write address
- data_in  in  DATA_W  write data
- write_en  in  1  write request, sampled each edge
- read_en  in  1  read request, sampled each edge
- data_out  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse: data_out updated by a read
- wr_err  out  1  one-cycle pulse: previous write rejected
- rd_err  out  1  one-cycle pulse, coincident with rd_valid: previous read out of range
- locked  out  1  high unless the FSM is in UNLOCKED

## Operation
- Storage: DEPTH × DATA_W flops. All entries reset to 0.
- Write at an edge with write_en=1:
  - addr ≥ DEPTH: no store; wr_err pulses.
  - addr == KEY_ADDR: no store; drives the key FSM.
  - Protected addr: stored only if the FSM is in UNLOCKED that cycle. Otherwise no store and wr_err pulses.
  - Any other addr: stored unconditionally.
- Read at an edge with read_en=1: data_out is loaded and rd_valid pulses.
  - addr < DEPTH, not KEY_ADDR: data_out = entry contents.
  - addr == KEY_ADDR: data_out = {zeros, state[1:0]}, with LOCKED=0, KEY1_OK=1, UNLOCKED=2.
  - addr ≥ DEPTH: data_out = 0 and rd_err pulses.
- Read and write in the same cycle (shared addr): the write proceeds; the read returns the pre-write contents.
- Key FSM states: LOCKED, KEY1_OK, UNLOCKED.
  - LOCKED: write KEY_ADDR with 0x55 → KEY1_OK. Any other data → stay LOCKED.
  - KEY1_OK: write KEY_ADDR with 0xAA → UNLOCKED. Any other write, to any address, → LOCKED. Idle cycles hold the state.
  - UNLOCKED: an accepted protected write → LOCKED after that edge (one write per unlock). Write KEY_ADDR with 0x55 → KEY1_OK; any other KEY_ADDR data → LOCKED. Timeout expiry → LOCKED. Unprotected writes and all reads do not change state.
- Timeout counter: loads UNLOCK_TMO on entry to UNLOCKED and decrements each UNLOCKED cycle. The FSM stays in UNLOCKED for exactly UNLOCK_TMO cycles unless it leaves earlier.
- data_out holds its last value when no read occurs.

## Timing
- Reset (rst_n low at an edge) sets:
  - data_out = 0, rd_valid = 0, wr_err = 0, rd_err = 0
  - locked = 1, FSM = LOCKED, counter = 0, all entries = 0
  - Requests in the same cycle are ignored. A read issued the cycle before reset produces no rd_valid.
- Read latency is 1: read_en sampled at edge N gives data_out and rd_valid valid after edge N. rd_valid drops after edge N+1 unless read_en is high again. Back-to-back reads return one result per cycle.
- Write latency is 1: a write at edge N is visible to a read sampled at edge N+1.
- wr_err asserts after the edge that sampled the rejected write, for one cycle.
- locked deasserts after the edge that accepts 0xAA. It reasserts after the edge of the protected write, or after UNLOCK_TMO cycles of UNLOCKED.
- No backpressure: every request completes; no stall or handshake.

## Test plan
- Reset, then write 10, 15, 20, 25, 30 to addresses 0..4, then read 0..4 → data_out = 10, 15, 20, 25, 30, each with rd_valid one cycle after its read_en; wr_err stays 0.
- Write 0x3C to addr 9 while LOCKED → wr_err pulses; read 9 returns 0.
- Write KEY_ADDR 0x55, then 0xAA, then 0x3C to addr 9 → locked falls after 0xAA and rises after the write; read 9 = 0x3C; a second write 0x11 to addr 9 is rejected with wr_err.
- Unlock, then idle UNLOCK_TMO=16 cycles, then write addr 10 → wr_err pulses; read KEY_ADDR returns 0. Write at cycle 16 after unlock → accepted.
- Write KEY_ADDR 0x55, then write 0x07 to addr 2, then KEY_ADDR 0xAA → addr 2 = 0x07, FSM still LOCKED, read KEY_ADDR = 0.
- Read addr 3 (holding 25) with write 0x40 to addr 3 in the same cycle → data_out = 25; next read = 0x40. Assert rst_n low mid-unlock → locked = 1, all entries 0.
